// File: rtl/selen_top.sv
// Selen fetch front end: sequential fetch unit streaming through a direct-mapped L1I
// backed by a read-only boot memory (word i holds value i).

module selen_boot_rom #(
    parameter int MEM_WORDS = 1024
) (
    input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
    output logic [31:0]                  o_data
);
    assign o_data = 32'(i_addr);
endmodule

module selen_l1i #(
    parameter int LINES       = 64,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [31:0]                  i_pc,
    input  logic [31:0]                  i_mem_data,
    output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
    output logic                         o_hit,
    output logic                         o_cache_ready,
    output logic                         o_fetch_valid,
    output logic [31:0]                  o_fetch_pc,
    output logic [31:0]                  o_fetch_instr,
    output logic [31:0]                  o_hit_cnt,
    output logic [31:0]                  o_miss_cnt
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int LAT_W  = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {S_INIT, S_LOOKUP, S_WAIT, S_REFILL} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_init_idx;
    logic [LAT_W-1:0]   r_wait_cnt;
    logic [OFF_W-1:0]   r_word;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES*LINE_WORDS];
    logic               cache_ready;
    logic               r_fetch_valid;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_fetch_instr;
    logic [31:0]        r_hit_cnt;
    logic [31:0]        r_miss_cnt;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_last_word;

    assign w_off       = i_pc[2 +: OFF_W];
    assign w_idx       = i_pc[2 + OFF_W +: IDX_W];
    assign w_tag       = i_pc[31 -: TAG_W];
    assign w_hit       = (r_state == S_LOOKUP) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last_word = (r_word == OFF_W'(LINE_WORDS - 1));

    // Refill reads the missing line from its base, one word per cycle; the memory wraps the index.
    assign o_mem_addr = MEM_AW'({i_pc[31:OFF_W+2], r_word});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_INIT;
            r_init_idx    <= '0;
            r_wait_cnt    <= '0;
            r_word        <= '0;
            r_valid       <= '0;
            cache_ready   <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
            r_fetch_instr <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
        end else begin
            r_fetch_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_valid[r_init_idx] <= 1'b0;
                    if (r_init_idx == IDX_W'(LINES - 1)) begin
                        cache_ready <= 1'b1;
                        r_state     <= S_LOOKUP;
                    end else begin
                        r_init_idx <= r_init_idx + IDX_W'(1);
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_pc    <= i_pc;
                        r_fetch_instr <= r_data[{w_idx, w_off}];
                        r_hit_cnt     <= r_hit_cnt + 32'd1;
                    end else begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == LAT_W'(MEM_LATENCY - 1)) begin
                        r_word  <= '0;
                        r_state <= S_REFILL;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + LAT_W'(1);
                    end
                end
                S_REFILL: begin
                    r_word <= r_word + OFF_W'(1);
                    if (w_last_word) begin
                        r_valid[w_idx] <= 1'b1;
                        r_state        <= S_LOOKUP;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Line storage needs no reset: the valid bits gate every read.
    always_ff @(posedge i_clk) begin
        if (r_state == S_REFILL) begin
            r_data[{w_idx, r_word}] <= i_mem_data;
            if (w_last_word) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

    assign o_hit         = w_hit;
    assign o_cache_ready = cache_ready;
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_pc    = r_fetch_pc;
    assign o_fetch_instr = r_fetch_instr;
    assign o_hit_cnt     = r_hit_cnt;
    assign o_miss_cnt    = r_miss_cnt;
endmodule

module selen_l1_cache #(
    parameter int LINES       = 64,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic        o_hit,
    output logic        o_cache_ready,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
);
    logic [$clog2(MEM_WORDS)-1:0] w_mem_addr;
    logic [31:0]                  w_mem_data;

    selen_boot_rom #(.MEM_WORDS(MEM_WORDS)) boot_rom (
        .i_addr (w_mem_addr),
        .o_data (w_mem_data)
    );

    selen_l1i #(
        .LINES       (LINES),
        .LINE_WORDS  (LINE_WORDS),
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (MEM_LATENCY)
    ) l1i (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc          (i_pc),
        .i_mem_data    (w_mem_data),
        .o_mem_addr    (w_mem_addr),
        .o_hit         (o_hit),
        .o_cache_ready (o_cache_ready),
        .o_fetch_valid (o_fetch_valid),
        .o_fetch_pc    (o_fetch_pc),
        .o_fetch_instr (o_fetch_instr),
        .o_hit_cnt     (o_hit_cnt),
        .o_miss_cnt    (o_miss_cnt)
    );
endmodule

module selen_cpu_cluster #(
    parameter int          LINES       = 64,
    parameter int          LINE_WORDS  = 4,
    parameter int          MEM_WORDS   = 1024,
    parameter int          MEM_LATENCY = 4,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_cache_ready,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
);
    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1);

    logic [31:0] r_pc;
    logic        w_hit;

    // The PC only advances on a hit, so a miss simply retries the same address after refill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (w_hit) begin
            r_pc <= (r_pc + 32'd4) & PC_MASK;
        end
    end

    selen_l1_cache #(
        .LINES       (LINES),
        .LINE_WORDS  (LINE_WORDS),
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (MEM_LATENCY)
    ) l1_cache (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc          (r_pc),
        .o_hit         (w_hit),
        .o_cache_ready (o_cache_ready),
        .o_fetch_valid (o_fetch_valid),
        .o_fetch_pc    (o_fetch_pc),
        .o_fetch_instr (o_fetch_instr),
        .o_hit_cnt     (o_hit_cnt),
        .o_miss_cnt    (o_miss_cnt)
    );
endmodule

module selen_top #(
    parameter int          LINES       = 64,
    parameter int          LINE_WORDS  = 4,
    parameter int          MEM_WORDS   = 1024,
    parameter int          MEM_LATENCY = 4,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cache_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    selen_cpu_cluster #(
        .LINES       (LINES),
        .LINE_WORDS  (LINE_WORDS),
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (MEM_LATENCY),
        .RESET_PC    (RESET_PC)
    ) cpu_cluster (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_cache_ready (cache_ready),
        .o_fetch_valid (fetch_valid),
        .o_fetch_pc    (fetch_pc),
        .o_fetch_instr (fetch_instr),
        .o_hit_cnt     (hit_cnt),
        .o_miss_cnt    (miss_cnt)
    );
endmodule

// File: tb/tb_selen_top.sv
// Bench for selen_top: a cache-level reference model predicts every delivery (edge, pc, instr,
// counters) into a queue; an independent negedge monitor pops and compares.
module tb_selen_top;
    localparam int LINES = 64;
    localparam int LW    = 4;
    localparam int MEMW  = 1024;
    localparam int LAT   = 4;
    localparam int N1    = 1032;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    selen_top #(
        .LINES(LINES), .LINE_WORDS(LW), .MEM_WORDS(MEMW), .MEM_LATENCY(LAT), .RESET_PC(32'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cache_ready (cache_ready),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    typedef struct {
        int unsigned edge_no;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned edge_no = 0;
    bit          mon_en = 1'b0;

    // Reference model: which line/tag is resident, and when each instruction must appear.
    bit          m_valid[LINES];
    int unsigned m_tag[LINES];
    int unsigned m_pc, m_t, m_hits, m_misses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_pc = 0; m_t = LINES; m_hits = 0; m_misses = 0;
    endfunction

    function automatic exp_t model_step(output bit was_miss);
        exp_t        e;
        int unsigned wa  = m_pc / 4;
        int unsigned idx = (wa / LW) % LINES;
        int unsigned tag = wa / (LW * LINES);
        was_miss = !(m_valid[idx] && m_tag[idx] == tag);
        if (was_miss) begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_t += LAT + LW + 2;
        end else begin
            m_t += 1;
        end
        m_hits++;
        e.edge_no = m_t;
        e.pc      = m_pc;
        e.instr   = wa % MEMW;
        e.hits    = m_hits;
        e.misses  = m_misses;
        m_pc = (m_pc + 4) % (MEMW * 4);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) edge_no = 0;
        else     edge_no = edge_no + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {31'd0, cache_ready} | {31'd0, fetch_valid} | fetch_pc |
                  fetch_instr | hit_cnt | miss_cnt, 32'd0);
        end else begin
            check("hier_cache_ready", {31'd0, dut.cpu_cluster.l1_cache.l1i.cache_ready},
                  {31'd0, cache_ready});
            if (edge_no < LINES) begin
                check("init_cache_ready", {31'd0, cache_ready}, 32'd0);
                check("init_fetch_valid", {31'd0, fetch_valid}, 32'd0);
            end else begin
                check("cache_ready_high", {31'd0, cache_ready}, 32'd1);
            end
            if (mon_en) begin
                if (fetch_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch: got pc %0d, expected no delivery", fetch_pc);
                    end else begin
                        mon_e = q.pop_front();
                        check("deliver_edge", edge_no, mon_e.edge_no);
                        check("fetch_pc", fetch_pc, mon_e.pc);
                        check("fetch_instr", fetch_instr, mon_e.instr);
                        check("hit_cnt", hit_cnt, mon_e.hits);
                        check("miss_cnt", miss_cnt, mon_e.misses);
                    end
                end else if (q.size() > 0 && q[0].edge_no == edge_no) begin
                    mon_e = q.pop_front();
                    checks++; errors++;
                    $display("FAIL missed_fetch: got no delivery, expected pc %0d at edge %0d",
                             mon_e.pc, mon_e.edge_no);
                end
            end
        end
    end

    initial begin
        exp_t        e;
        bit          miss;
        int unsigned target;
        int unsigned hits_before;
        int          budget;
        int          n2;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        // Long stream covering every line twice over plus the PC wrap; stop at a later refill.
        model_reset();
        target = 0;
        for (int k = 0; k < 4 * N1; k++) begin
            hits_before = m_hits;
            e = model_step(miss);
            if (miss && k >= N1) begin
                target = e.edge_no - LW - 1 + $urandom_range(0, LW - 1);
                break;
            end
            q.push_back(e);
        end
        mon_en = 1'b1;
        rst    = 1'b0;

        budget = 0;
        while (edge_no < target && budget < 20000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("reach_refill_timeout", {31'd0, edge_no == target}, 32'd1);
        check("queue_drained", q.size(), 32'd0);
        check("pre_reset_hits", hit_cnt, hits_before);
        check("pre_reset_misses", miss_cnt, m_misses);

        // Reset lands inside REFILL and must clear outputs without waiting for a clock.
        rst = 1'b1;
        q.delete();
        #1;
        check("async_rst_ready", {31'd0, cache_ready}, 32'd0);
        check("async_rst_hit_cnt", hit_cnt, 32'd0);
        check("async_rst_miss_cnt", miss_cnt, 32'd0);
        check("async_rst_valid", {31'd0, fetch_valid}, 32'd0);
        repeat (1 + $urandom_range(0, 3)) @(posedge clk);
        #1;

        model_reset();
        n2 = 48 + $urandom_range(0, 40);
        for (int k = 0; k < n2; k++) begin
            e = model_step(miss);
            q.push_back(e);
        end
        rst = 1'b0;

        budget = 0;
        while (q.size() > 0 && budget < 5000) begin
            @(negedge clk); #1;
            budget++;
        end
        mon_en = 1'b0;
        check("phase3_drain_timeout", q.size(), 32'd0);
        check("final_hit_cnt", hit_cnt, m_hits);
        check("final_miss_cnt", miss_cnt, m_misses);
        check("final_lookups", hit_cnt + miss_cnt, m_hits + m_misses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
